// File: rtl/mem_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_dma_ctrl
// Description : Word-copy DMA engine moving data from the shared dmem port
//               into imem, with strict CPU priority on the dmem port.
//               Ports:
//                 clk, rst             - clock, synchronous active-high reset
//                 cpu_req/we/addr/din  - CPU dmem access (passed straight through)
//                 cfg_start/src/dst/len, cfg_abort - copy launch and abort
//                 busy, done           - copy in progress, sticky completion
//                 dmem_en/we/addr/din, dmem_dout - shared dmem port
//                 imem_wea/addra/dina  - imem write port
// Revision    : 1.0 - initial release
// ============================================================================
module mem_dma_ctrl #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic [3:0]    cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_din,
  input  logic          cfg_start,
  input  logic [AW-1:0] cfg_src,
  input  logic [AW-1:0] cfg_dst,
  input  logic [AW-1:0] cfg_len,
  input  logic          cfg_abort,
  output logic          busy,
  output logic          done,
  output logic          dmem_en,
  output logic [3:0]    dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [31:0]   dmem_din,
  input  logic [31:0]   dmem_dout,
  output logic [3:0]    imem_wea,
  output logic [AW-1:0] imem_addra,
  output logic [31:0]   imem_dina
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [AW-1:0] C_ONE = AW'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [AW-1:0] r_rem;
  logic          r_done;
  logic [AW-1:0] w_rem_dec;

  assign w_rem_dec = r_rem - C_ONE;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

  // State register and copy bookkeeping. Pointers wrap naturally at 2^AW.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (cfg_start && !cfg_abort) begin
            r_src  <= cfg_src;
            r_dst  <= cfg_dst;
            r_rem  <= cfg_len;
            // A zero-length copy completes immediately without touching memory.
            r_done <= (cfg_len == '0);
          end
        end
        S_WRITE: begin
          r_src <= r_src + C_ONE;
          r_dst <= r_dst + C_ONE;
          r_rem <= w_rem_dec;
          // An abort landing on the final write leaves done clear.
          if (!cfg_abort && (w_rem_dec == '0)) begin
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (cfg_start && !cfg_abort && (cfg_len != '0)) begin
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (cfg_abort) begin
          w_state_nxt = S_IDLE;
        end else if (!cpu_req) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (cfg_abort || (w_rem_dec == '0)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_READ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Port muxing. The CPU owns dmem whenever it asks; the DMA read only goes
  // out when the port is free. The imem write uses the data returned for the
  // read issued in the preceding READ cycle, so it never needs the dmem port.
  always_comb begin
    dmem_en    = 1'b0;
    dmem_we    = 4'h0;
    dmem_addr  = '0;
    dmem_din   = 32'h0;
    imem_wea   = 4'h0;
    imem_addra = '0;
    imem_dina  = 32'h0;
    if (cpu_req) begin
      dmem_en   = 1'b1;
      dmem_we   = cpu_we;
      dmem_addr = cpu_addr;
      dmem_din  = cpu_din;
    end else if (r_state == S_READ) begin
      dmem_en   = 1'b1;
      dmem_addr = r_src;
    end
    if (r_state == S_WRITE) begin
      imem_wea   = 4'hF;
      imem_addra = r_dst;
      imem_dina  = dmem_dout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_dma_ctrl
// Description : Directed self-checking bench for mem_dma_ctrl with a
//               behavioural dmem (1-cycle read latency) and an imem capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dma_ctrl;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic [3:0]    cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_din;
  logic          cfg_start;
  logic [AW-1:0] cfg_src;
  logic [AW-1:0] cfg_dst;
  logic [AW-1:0] cfg_len;
  logic          cfg_abort;
  logic          busy;
  logic          done;
  logic          dmem_en;
  logic [3:0]    dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_din;
  logic [31:0]   dmem_dout;
  logic [3:0]    imem_wea;
  logic [AW-1:0] imem_addra;
  logic [31:0]   imem_dina;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]   dmem [0:(1<<AW)-1];
  logic [31:0]   imem [0:(1<<AW)-1];
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wr_q[$];
  logic [31:0]   wd_q[$];
  logic [31:0]   exp_data [0:2];

  always #5 clk = ~clk;

  mem_dma_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cfg_start(cfg_start), .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .cfg_abort(cfg_abort), .busy(busy), .done(done),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
    .dmem_dout(dmem_dout),
    .imem_wea(imem_wea), .imem_addra(imem_addra), .imem_dina(imem_dina)
  );

  // dmem: byte-enabled writes, registered read data.
  always @(posedge clk) begin
    if (dmem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_we[b]) dmem[dmem_addr][8*b +: 8] <= dmem_din[8*b +: 8];
      end
      dmem_dout <= dmem[dmem_addr];
    end
  end

  // Log DMA reads and imem writes.
  always @(posedge clk) begin
    if (dmem_en && !cpu_req && (dmem_we == 4'h0)) rd_q.push_back(dmem_addr);
    if (imem_wea != 4'h0) begin
      imem[imem_addra] <= imem_dina;
      wr_q.push_back(imem_addra);
      wd_q.push_back(imem_dina);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [31:0] d);
    cpu_req = 1'b1; cpu_we = 4'hF; cpu_addr = a; cpu_din = d;
    tick();
    cpu_req = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_din = 32'h0;
  endtask

  task automatic clear_logs();
    rd_q.delete(); wr_q.delete(); wd_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_data[0] = 32'hA1A1_0001;
    exp_data[1] = 32'hB2B2_0002;
    exp_data[2] = 32'hC3C3_0003;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_din = 32'h0;
    cfg_start = 1'b0; cfg_src = '0; cfg_dst = '0; cfg_len = '0; cfg_abort = 1'b0;

    // CPU pass-through while reset is held.
    tick();
    cpu_req = 1'b1; cpu_we = 4'h3; cpu_addr = 14'h0AB; cpu_din = 32'h1234_5678;
    #2;
    chk("rst_pass_en", {31'd0, dmem_en}, 32'd1);
    chk("rst_pass_addr", {18'd0, dmem_addr}, 32'h0AB);
    chk("rst_pass_we", {28'd0, dmem_we}, 32'h3);
    chk("rst_pass_din", dmem_din, 32'h1234_5678);
    tick();
    cpu_req = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_din = 32'h0;
    rst = 1'b0;
    #2;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_dmem_en", {31'd0, dmem_en}, 32'd0);
    chk("reset_dmem_addr", {18'd0, dmem_addr}, 32'd0);
    chk("reset_imem_wea", {28'd0, imem_wea}, 32'd0);
    chk("reset_imem_addra", {18'd0, imem_addra}, 32'd0);

    // Preload source words through the CPU port.
    tick();
    cpu_write(14'h010, exp_data[0]);
    cpu_write(14'h011, exp_data[1]);
    cpu_write(14'h012, exp_data[2]);
    cpu_write(14'h3FFF, 32'h5555_0000);
    cpu_write(14'h0000, 32'h5555_0001);
    cpu_write(14'h0001, 32'h5555_0002);
    for (int i = 0; i < 5; i++) cpu_write(14'h100 + 14'(i), 32'h7000_0000 + i);

    // Basic copy: 0x10 -> 0x20, 3 words, no CPU traffic.
    cfg_src = 14'h010; cfg_dst = 14'h020; cfg_len = 14'd3; cfg_start = 1'b1;
    #2;
    chk("t1_busy_c0", {31'd0, busy}, 32'd0);
    tick();
    cfg_start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      #2;
      chk($sformatf("t1_busy_c%0d", k), {31'd0, busy}, 32'd1);
      chk($sformatf("t1_done_c%0d", k), {31'd0, done}, 32'd0);
      if (k % 2 == 1) begin
        chk($sformatf("t1_rd_en_c%0d", k), {31'd0, dmem_en}, 32'd1);
        chk($sformatf("t1_rd_addr_c%0d", k), {18'd0, dmem_addr}, 32'h010 + (k-1)/2);
        chk($sformatf("t1_rd_wea_c%0d", k), {28'd0, imem_wea}, 32'd0);
      end else begin
        chk($sformatf("t1_wr_wea_c%0d", k), {28'd0, imem_wea}, 32'hF);
        chk($sformatf("t1_wr_addr_c%0d", k), {18'd0, imem_addra}, 32'h020 + k/2 - 1);
        chk($sformatf("t1_wr_data_c%0d", k), imem_dina, exp_data[k/2-1]);
        chk($sformatf("t1_wr_den_c%0d", k), {31'd0, dmem_en}, 32'd0);
      end
      tick();
    end
    #2;
    chk("t1_busy_c7", {31'd0, busy}, 32'd0);
    chk("t1_done_c7", {31'd0, done}, 32'd1);
    for (int i = 0; i < 3; i++) chk($sformatf("t1_imem_%0d", i), imem[14'h020 + 14'(i)], exp_data[i]);
    tick();

    // Same copy to 0x40 with the CPU holding dmem for 4 READ cycles.
    cfg_dst = 14'h040; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cpu_req = 1'b1; cpu_addr = 14'h155;
      cpu_we = (k == 4) ? 4'h5 : 4'h0;
      cpu_din = (k == 4) ? 32'hDEAD_BEEF : 32'h0;
      #2;
      chk($sformatf("t2_cpu_addr_c%0d", k), {18'd0, dmem_addr}, 32'h155);
      chk($sformatf("t2_cpu_en_c%0d", k), {31'd0, dmem_en}, 32'd1);
      chk($sformatf("t2_wea_c%0d", k), {28'd0, imem_wea}, 32'd0);
      tick();
    end
    cpu_req = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_din = 32'h0;
    #2;
    chk("t2_cpu_we_written", dmem[14'h155] & 32'h00FF_00FF, 32'h00AD_00EF);
    chk("t2_resume_addr", {18'd0, dmem_addr}, 32'h010);
    for (int k = 5; k < 10; k++) tick();
    #2;
    chk("t2_busy_c10", {31'd0, busy}, 32'd1);
    chk("t2_done_c10", {31'd0, done}, 32'd0);
    tick();
    #2;
    chk("t2_busy_c11", {31'd0, busy}, 32'd0);
    chk("t2_done_c11", {31'd0, done}, 32'd1);
    for (int i = 0; i < 3; i++) chk($sformatf("t2_imem_%0d", i), imem[14'h040 + 14'(i)], exp_data[i]);
    tick();

    // Address wrap: src 0x3FFF, dst 0x3FFE, len 3.
    clear_logs();
    cfg_src = 14'h3FFF; cfg_dst = 14'h3FFE; cfg_len = 14'd3; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (busy && cyc < 20) begin tick(); cyc++; end
      chk("t3_finish_in_budget", {31'd0, busy}, 32'd0);
    end
    #2;
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_rd_count", rd_q.size(), 32'd3);
    chk("t3_wr_count", wr_q.size(), 32'd3);
    if (rd_q.size() == 3 && wr_q.size() == 3) begin
      chk("t3_rd0", {18'd0, rd_q[0]}, 32'h3FFF);
      chk("t3_rd1", {18'd0, rd_q[1]}, 32'h0000);
      chk("t3_rd2", {18'd0, rd_q[2]}, 32'h0001);
      chk("t3_wr0", {18'd0, wr_q[0]}, 32'h3FFE);
      chk("t3_wr1", {18'd0, wr_q[1]}, 32'h3FFF);
      chk("t3_wr2", {18'd0, wr_q[2]}, 32'h0000);
      chk("t3_wd0", wd_q[0], 32'h5555_0000);
      chk("t3_wd1", wd_q[1], 32'h5555_0001);
      chk("t3_wd2", wd_q[2], 32'h5555_0002);
    end
    tick();

    // Abort after the first WRITE of a 5-word copy; restarts while busy ignored.
    clear_logs();
    cfg_src = 14'h100; cfg_dst = 14'h200; cfg_len = 14'd5; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    #2;
    chk("t4_rd0_addr", {18'd0, dmem_addr}, 32'h100);
    tick();
    cfg_start = 1'b1; cfg_src = 14'h300; cfg_len = 14'd2;
    #2;
    chk("t4_first_write", {28'd0, imem_wea}, 32'hF);
    tick();
    cfg_abort = 1'b1;
    #2;
    chk("t4_rd1_addr", {18'd0, dmem_addr}, 32'h101);
    tick();
    cfg_start = 1'b0; cfg_abort = 1'b0;
    #2;
    chk("t4_busy_after_abort", {31'd0, busy}, 32'd0);
    chk("t4_done_after_abort", {31'd0, done}, 32'd0);
    chk("t4_wea_after_abort", {28'd0, imem_wea}, 32'd0);
    tick(); tick(); tick();
    chk("t4_wr_count", wr_q.size(), 32'd1);
    chk("t4_still_idle", {31'd0, busy}, 32'd0);

    // Zero-length start: done next cycle, no memory traffic.
    clear_logs();
    cfg_src = 14'h010; cfg_dst = 14'h080; cfg_len = 14'd0; cfg_start = 1'b1;
    #2;
    chk("t5_den_c0", {31'd0, dmem_en}, 32'd0);
    tick();
    cfg_start = 1'b0;
    #2;
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_den_c1", {31'd0, dmem_en}, 32'd0);
    chk("t5_wea_c1", {28'd0, imem_wea}, 32'd0);
    tick(); tick();
    chk("t5_done_sticky", {31'd0, done}, 32'd1);
    chk("t5_rd_count", rd_q.size(), 32'd0);
    chk("t5_wr_count", wr_q.size(), 32'd0);

    // Reset during READ.
    clear_logs();
    cfg_src = 14'h010; cfg_dst = 14'h060; cfg_len = 14'd3; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0; rst = 1'b1;
    #2;
    chk("t6_read_addr", {18'd0, dmem_addr}, 32'h010);
    chk("t6_busy_in_read", {31'd0, busy}, 32'd1);
    tick();
    rst = 1'b0;
    #2;
    chk("t6_busy_after_rst", {31'd0, busy}, 32'd0);
    chk("t6_done_after_rst", {31'd0, done}, 32'd0);
    chk("t6_wea_after_rst", {28'd0, imem_wea}, 32'd0);
    tick(); tick(); tick();
    chk("t6_wr_count", wr_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
